// File: rtl/tnn_stream_pkg.sv
// Shared types and sizing helpers for the TNN stream controller and its result packer.
package tnn_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BURST    = 2'd1,
        ST_WAIT_RES = 2'd2
    } tnn_state_t;

    // Number of result lanes in one packed output word.
    function automatic int pack_ratio(input int pack_w, input int res_w);
        return pack_w / res_w;
    endfunction

    // Bits needed to count 0..n-1 (never less than one).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tnn_result_packer.sv
// Packs RES_W results little-endian into PACK_W words; the completed word lands in the output register one cycle after its last result.
// No backpressure to the core: a word completing while the output register is still unaccepted is dropped and flagged.
module tnn_result_packer
    import tnn_stream_pkg::*;
#(
    parameter int RES_W       = 64,
    parameter int PACK_W      = 512,
    parameter int RES_PER_IMG = 160
) (
    input  logic              clk_a1,
    input  logic              reset,
    input  logic              res_vld,
    input  logic [RES_W-1:0]  res_data,
    input  logic              out_rdy,
    output logic              out_vld,
    output logic [PACK_W-1:0] out_data,
    output logic              out_last,
    output logic              drop,
    output logic              img_done
);

    localparam int RATIO = pack_ratio(PACK_W, RES_W);
    localparam int LN_W  = cnt_width(RATIO);
    localparam int RC_W  = cnt_width(RES_PER_IMG);

    logic [LN_W-1:0]   lane;
    logic [RC_W-1:0]   res_cnt;
    logic [PACK_W-1:0] acc;
    logic [PACK_W-1:0] acc_nxt;
    logic              last_res;
    logic              word_done;
    logic              out_free;

    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < RATIO; i++) begin
            if (lane == LN_W'(i)) acc_nxt[i*RES_W +: RES_W] = res_data;
        end
        last_res  = (res_cnt == RC_W'(RES_PER_IMG - 1));
        word_done = res_vld && (last_res || lane == LN_W'(RATIO - 1));
        out_free  = !out_vld || out_rdy;
    end

    assign drop = word_done && !out_free;

    always_ff @(posedge clk_a1) begin
        if (reset) begin
            lane     <= '0;
            res_cnt  <= '0;
            acc      <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
            img_done <= 1'b0;
        end else begin
            img_done <= 1'b0;
            if (out_vld && out_rdy) begin
                out_vld  <= 1'b0;
                out_last <= 1'b0;
            end
            if (res_vld) begin
                if (word_done) begin
                    // Lanes restart from zero so a short final word has zero padding.
                    acc  <= '0;
                    lane <= '0;
                    if (out_free) begin
                        out_vld  <= 1'b1;
                        out_data <= acc_nxt;
                        out_last <= last_res;
                    end
                end else begin
                    acc  <= acc_nxt;
                    lane <= lane + 1'b1;
                end
                res_cnt  <= last_res ? '0 : res_cnt + 1'b1;
                img_done <= last_res;
            end
        end
    end

endmodule

// File: rtl/tnn_stream_ctrl.sv
// Bursts one image from the upstream FIFO into the core (data latency 1) and packs the core results for output.
// Bursts start only when a whole image is buffered; output backpressure never stalls the core, overruns set ovf_err.
module tnn_stream_ctrl
    import tnn_stream_pkg::*;
#(
    parameter int IN_W        = 64,
    parameter int RES_W       = 64,
    parameter int PACK_W      = 512,
    parameter int IMG_WORDS   = 1024,
    parameter int RES_PER_IMG = 160,
    parameter int LVL_W       = 12
) (
    input  logic              clk_a1,
    input  logic              reset,
    input  logic              enable,
    input  logic [LVL_W-1:0]  in_level,
    output logic              in_rd_en,
    input  logic              in_vld,
    input  logic [IN_W-1:0]   in_data,
    output logic              core_vld,
    output logic [IN_W-1:0]   core_data,
    input  logic              res_vld,
    input  logic [RES_W-1:0]  res_data,
    output logic              out_vld,
    output logic [PACK_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_rdy,
    output logic [31:0]       img_cnt,
    output logic              ovf_err
);

    localparam int BC_W = cnt_width(IMG_WORDS);

    tnn_state_t      state;
    logic [BC_W-1:0] burst_cnt;
    logic            done_seen;
    logic            pk_vld;
    logic            pk_drop;
    logic            pk_done;

    // Results arriving with no image in flight are discarded.
    assign pk_vld = res_vld && (state != ST_IDLE);

    tnn_result_packer #(
        .RES_W       (RES_W),
        .PACK_W      (PACK_W),
        .RES_PER_IMG (RES_PER_IMG)
    ) u_packer (
        .clk_a1   (clk_a1),
        .reset    (reset),
        .res_vld  (pk_vld),
        .res_data (res_data),
        .out_rdy  (out_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_last (out_last),
        .drop     (pk_drop),
        .img_done (pk_done)
    );

    always_ff @(posedge clk_a1) begin
        if (reset) begin
            state     <= ST_IDLE;
            in_rd_en  <= 1'b0;
            burst_cnt <= '0;
            img_cnt   <= '0;
            done_seen <= 1'b0;
            ovf_err   <= 1'b0;
            core_vld  <= 1'b0;
            core_data <= '0;
        end else begin
            core_vld  <= in_vld;
            core_data <= in_data;
            if ((res_vld && state == ST_IDLE) || pk_drop) ovf_err <= 1'b1;
            case (state)
                ST_IDLE: begin
                    done_seen <= 1'b0;
                    if (enable && in_level >= LVL_W'(IMG_WORDS)) begin
                        state     <= ST_BURST;
                        in_rd_en  <= 1'b1;
                        burst_cnt <= BC_W'(IMG_WORDS - 1);
                    end
                end
                ST_BURST: begin
                    // A fast core may finish its results before the burst ends.
                    if (pk_done) done_seen <= 1'b1;
                    if (burst_cnt == '0) begin
                        state    <= ST_WAIT_RES;
                        in_rd_en <= 1'b0;
                        img_cnt  <= img_cnt + 32'd1;
                    end else begin
                        burst_cnt <= burst_cnt - 1'b1;
                    end
                end
                ST_WAIT_RES: begin
                    if (pk_done || done_seen) begin
                        state     <= ST_IDLE;
                        done_seen <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tnn_stream_ctrl.sv
// Bench for tnn_stream_ctrl: default instance plus a short-image instance (10 results, 16 words).
module tb_tnn_stream_ctrl;

    localparam int IN_W = 64, RES_W = 64, PACK_W = 512, RATIO = 8;
    localparam int IMG_WORDS = 1024, RES_PER_IMG = 160, LVL_W = 12;
    localparam int B_IMG = 16, B_RES = 10;

    logic clk_a1 = 1'b0;
    always #5 clk_a1 = ~clk_a1;

    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [LVL_W-1:0]  in_level = '0;
    logic              in_rd_en;
    logic              in_vld = 1'b0;
    logic [IN_W-1:0]   in_data = '0;
    logic              core_vld;
    logic [IN_W-1:0]   core_data;
    logic              res_vld = 1'b0;
    logic [RES_W-1:0]  res_data = '0;
    logic              out_vld;
    logic [PACK_W-1:0] out_data;
    logic              out_last;
    logic              out_rdy = 1'b1;
    logic [31:0]       img_cnt;
    logic              ovf_err;

    logic              b_enable = 1'b0;
    logic [LVL_W-1:0]  b_in_level = '0;
    logic              b_in_rd_en;
    logic              b_in_vld = 1'b0;
    logic [IN_W-1:0]   b_in_data = '0;
    logic              b_core_vld;
    logic [IN_W-1:0]   b_core_data;
    logic              b_res_vld = 1'b0;
    logic [RES_W-1:0]  b_res_data = '0;
    logic              b_out_vld;
    logic [PACK_W-1:0] b_out_data;
    logic              b_out_last;
    logic              b_out_rdy = 1'b1;
    logic [31:0]       b_img_cnt;
    logic              b_ovf_err;

    tnn_stream_ctrl u_dut (
        .clk_a1(clk_a1), .reset(reset), .enable(enable), .in_level(in_level),
        .in_rd_en(in_rd_en), .in_vld(in_vld), .in_data(in_data),
        .core_vld(core_vld), .core_data(core_data),
        .res_vld(res_vld), .res_data(res_data),
        .out_vld(out_vld), .out_data(out_data), .out_last(out_last), .out_rdy(out_rdy),
        .img_cnt(img_cnt), .ovf_err(ovf_err)
    );

    tnn_stream_ctrl #(.IMG_WORDS(B_IMG), .RES_PER_IMG(B_RES)) u_dut_short (
        .clk_a1(clk_a1), .reset(reset), .enable(b_enable), .in_level(b_in_level),
        .in_rd_en(b_in_rd_en), .in_vld(b_in_vld), .in_data(b_in_data),
        .core_vld(b_core_vld), .core_data(b_core_data),
        .res_vld(b_res_vld), .res_data(b_res_data),
        .out_vld(b_out_vld), .out_data(b_out_data), .out_last(b_out_last), .out_rdy(b_out_rdy),
        .img_cnt(b_img_cnt), .ovf_err(b_ovf_err)
    );

    int checks = 0;
    int errors = 0;
    int rd_total = 0;
    int img_model = 0;
    bit pend = 1'b0;
    bit prev_rst = 1'b1;
    bit prev_in_vld = 1'b0;
    logic [IN_W-1:0] prev_in_data = '0;

    // Expected packed words, in acceptance order.
    logic [PACK_W-1:0] exp_word [512];
    bit                exp_last [512];
    int                wr_ptr = 0;
    int                rd_ptr = 0;

    typedef struct {
        logic             en;
        logic [LVL_W-1:0] lvl;
        bit               start;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string nm, input logic [PACK_W-1:0] act, input logic [PACK_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_a1);
        #1;
    endtask

    // Upstream FIFO: a read strobe in one cycle yields valid data in the next.
    task automatic responder();
        forever begin
            @(posedge clk_a1);
            #2;
            in_vld  = pend && !reset;
            in_data = {$urandom, $urandom};
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk_a1);
            if (in_rd_en) rd_total++;
            pend = in_rd_en;
            chk("core_vld", core_vld, prev_rst ? 1'b0 : prev_in_vld);
            if (!prev_rst && prev_in_vld) chk("core_data", core_data, prev_in_data);
            prev_rst     = reset;
            prev_in_vld  = in_vld;
            prev_in_data = in_data;
            if (out_vld && out_rdy) begin
                if (rd_ptr == wr_ptr) begin
                    chk("out_unexpected", out_vld, 1'b0);
                end else begin
                    chk("out_data", out_data, exp_word[rd_ptr]);
                    chk("out_last", out_last, exp_last[rd_ptr]);
                    rd_ptr++;
                end
            end
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_in_rd_en", in_rd_en, 1'b0);
        chk("rst_core_vld", core_vld, 1'b0);
        chk("rst_core_data", core_data, '0);
        chk("rst_out_vld", out_vld, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_img_cnt", img_cnt, '0);
        chk("rst_ovf_err", ovf_err, 1'b0);
    endtask

    // Waits out a burst already running, then checks its length and the image count.
    task automatic finish_burst(input int base);
        int n;
        n = 0;
        while (in_rd_en && n < 1200) begin
            tick();
            n++;
        end
        chk("burst_end_timeout", in_rd_en, 1'b0);
        chk("burst_reads", rd_total - base, IMG_WORDS);
        img_model++;
        chk("img_cnt", img_cnt, img_model);
    endtask

    task automatic do_burst(input logic [LVL_W-1:0] lvl, input int drop_after);
        int base;
        int n;
        base     = rd_total;
        enable   = 1'b1;
        in_level = lvl;
        n = 0;
        while (!in_rd_en && n < 10) begin
            tick();
            n++;
        end
        chk("burst_start", in_rd_en, 1'b1);
        n = 0;
        while (rd_total - base < drop_after && n < 1200) begin
            tick();
            n++;
        end
        enable = 1'b0;
        finish_burst(base);
    endtask

    // rdy_mode: 0 always ready, 1 random (never more than 3 stalls), 2 low for the first 20 cycles.
    task automatic feed_image(input bit full_rate, input int rdy_mode, input int skip_word);
        logic [RES_W-1:0]  r [RES_PER_IMG];
        logic [PACK_W-1:0] w;
        logic [PACK_W-1:0] held;
        int nw, idx, t, stall, first_ptr, n;
        bit stable;
        nw = (RES_PER_IMG + RATIO - 1) / RATIO;
        for (int i = 0; i < RES_PER_IMG; i++) r[i] = {$urandom, $urandom};
        first_ptr = wr_ptr;
        for (int k = 0; k < nw; k++) begin
            w = '0;
            for (int l = 0; l < RATIO; l++)
                if (k * RATIO + l < RES_PER_IMG) w[l*RES_W +: RES_W] = r[k*RATIO + l];
            if (k != skip_word) begin
                exp_word[wr_ptr] = w;
                exp_last[wr_ptr] = (k == nw - 1);
                wr_ptr++;
            end
        end
        idx = 0; t = 0; stall = 0; stable = 1'b1; held = '0;
        while (idx < RES_PER_IMG) begin
            tick();
            if (rdy_mode == 2 && t == 8) held = out_data;
            if (rdy_mode == 2 && t > 8 && t < 20 && (out_data !== held || out_vld !== 1'b1)) stable = 1'b0;
            case (rdy_mode)
                0: out_rdy = 1'b1;
                1: begin
                    out_rdy = (stall >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
                    stall   = out_rdy ? 0 : stall + 1;
                end
                default: out_rdy = (t >= 20);
            endcase
            res_vld  = full_rate || ($urandom_range(0, 3) != 0);
            res_data = res_vld ? r[idx] : {$urandom, $urandom};
            if (res_vld) idx++;
            t++;
        end
        tick();
        res_vld = 1'b0;
        out_rdy = 1'b1;
        if (rdy_mode == 2) begin
            chk("hold_stable", stable, 1'b1);
            chk("hold_word0", held, exp_word[first_ptr]);
        end
        n = 0;
        while (rd_ptr != wr_ptr && n < 300) begin
            tick();
            n++;
        end
        chk("drain_timeout", rd_ptr, wr_ptr);
        repeat (3) tick();
    endtask

    initial begin
        int base, nb, started;
        logic [RES_W-1:0]  br [B_RES];
        logic [PACK_W-1:0] bexp [2];
        logic [PACK_W-1:0] bgot [2];
        bit                blast [2];
        logic [PACK_W-1:0] upper;

        vecs[0] = '{1'b1, 12'd1023, 1'b0};
        vecs[1] = '{1'b0, 12'd1024, 1'b0};
        vecs[2] = '{1'b1, 12'd1024, 1'b1};
        vecs[3] = '{1'b0, 12'd4095, 1'b0};
        vecs[4] = '{1'b1, 12'd0,    1'b0};
        vecs[5] = '{1'b1, 12'd2048, 1'b1};
        vecs[6] = '{1'b1, 12'd1025, 1'b1};

        fork
            responder();
            monitor();
        join_none

        repeat (3) tick();
        check_reset_vals();
        chk("b_rst_img_cnt", b_img_cnt, '0);
        reset = 1'b0;
        tick();

        // Short-image instance: 10 results give one full word and one padded final word.
        b_enable = 1'b1;
        b_in_level = 12'd16;
        nb = 0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (b_in_rd_en) nb++;
            if (n == 2) b_enable = 1'b0;
        end
        chk("b_burst_reads", nb, B_IMG);
        chk("b_img_cnt", b_img_cnt, 1);
        for (int i = 0; i < B_RES; i++) br[i] = {$urandom, $urandom};
        bexp[0] = '0;
        bexp[1] = '0;
        for (int i = 0; i < B_RES; i++) bexp[i / RATIO][(i % RATIO)*RES_W +: RES_W] = br[i];
        nb = 0;
        for (int t = 0; t < 25; t++) begin
            tick();
            if (b_out_vld) begin
                if (nb < 2) begin
                    bgot[nb]  = b_out_data;
                    blast[nb] = b_out_last;
                end
                nb++;
            end
            b_res_vld  = (t < B_RES);
            b_res_data = (t < B_RES) ? br[t] : '0;
        end
        chk("b_word_count", nb, 2);
        chk("b_word0", bgot[0], bexp[0]);
        chk("b_word0_lane0", bgot[0][RES_W-1:0], br[0]);
        chk("b_word1", bgot[1], bexp[1]);
        upper = bgot[1] >> (2 * RES_W);
        chk("b_word1_lanes2to7", upper, '0);
        chk("b_last0", blast[0], 1'b0);
        chk("b_last1", blast[1], 1'b1);
        chk("b_ovf_err", b_ovf_err, 1'b0);

        // Start condition table: enable gates, level must cover a full image.
        for (int v = 0; v < 7; v++) begin
            base     = rd_total;
            enable   = vecs[v].en;
            in_level = vecs[v].lvl;
            repeat (4) tick();
            started = (rd_total != base);
            chk("start_vec", started, vecs[v].start);
            enable = 1'b0;
            if (started != 0) begin
                finish_burst(base);
                feed_image(1'b0, 1, -1);
            end
        end
        chk("ovf_after_table", ovf_err, 1'b0);

        // Full-rate results, always ready: 20 words, last only on the 20th.
        do_burst(12'd1024, 1);
        base = rd_ptr;
        feed_image(1'b1, 0, -1);
        chk("full_rate_words", rd_ptr - base, 20);
        chk("full_rate_ovf", ovf_err, 1'b0);

        // Enable dropped mid-burst: burst still completes, nothing further starts.
        do_burst(12'd2048, 100);
        feed_image(1'b0, 1, -1);
        base = rd_total;
        repeat (50) tick();
        chk("no_burst_while_disabled", rd_total - base, 0);

        // Output held off for 20 cycles: second word is dropped and flagged.
        do_burst(12'd1024, 1);
        feed_image(1'b1, 2, 1);
        chk("ovf_on_drop", ovf_err, 1'b1);

        // Reset mid-burst abandons the image; a fresh image runs afterwards.
        base     = rd_total;
        enable   = 1'b1;
        in_level = 12'd1024;
        for (int n = 0; n < 600 && rd_total - base < 500; n++) tick();
        chk("reads_before_reset", rd_total - base, 500);
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        check_reset_vals();
        tick();
        reset     = 1'b0;
        img_model = 0;
        tick();
        do_burst(12'd1024, 1);
        feed_image(1'b0, 1, -1);
        chk("ovf_after_reset_image", ovf_err, 1'b0);

        // A result arriving while idle is discarded and flagged.
        res_vld  = 1'b1;
        res_data = {$urandom, $urandom};
        tick();
        res_vld = 1'b0;
        tick();
        chk("idle_result_ovf", ovf_err, 1'b1);
        chk("idle_result_no_out", out_vld, 1'b0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
